// File: rtl/mem_bus_pkg.sv
// Shared types for the PicoRV32-style native memory bus arbiter.
//   arb_state_t       : arbiter FSM encoding (IDLE, BUSY0, BUSY1)
//   mem_req_t         : request bundle (valid, instr, addr, wdata, wstrb)
//   mem_rsp_t         : response bundle (ready, rdata)
//   ERR_RDATA_DEFAULT : read data returned on a watchdog timeout
package mem_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } mem_req_t;

    typedef struct packed {
        logic        ready;
        logic [31:0] rdata;
    } mem_rsp_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hDEAD_DEAD;

endpackage

// File: rtl/mem_arbiter2_if.sv
// One native memory bus link.
//   master modport : drives mem_valid/instr/addr/wdata/wstrb, receives mem_ready/rdata
//   slave modport  : receives the request, drives mem_ready/rdata
interface mem_arbiter2_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/rr_pick2.sv
// Two-way round-robin pick, purely combinational.
//   req_i      : request bits, [0] = port 0, [1] = port 1
//   last_gnt_i : port most recently served (0 or 1)
//   gnt_o      : one-hot grant, all zero when nothing requests
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            // Contention: favour the port that was not served last.
            2'b11:   gnt_o = last_gnt_i ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Two-master round-robin arbiter in front of a single native-bus slave.
//   clk, resetn : clock, asynchronous active-low reset
//   m0, m1      : master links (m0 = CPU, m1 = loader/debug)
//   s           : slave link, request driven combinationally from the granted master
//   timeout_err : one-cycle pulse when the stall watchdog forces completion
// Parameters: TIMEOUT_CYCLES (0 disables the watchdog), ERR_RDATA (data on timeout).
module mem_arbiter2
    import mem_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic           clk,
    input  logic           resetn,
    mem_arbiter2_if.slave  m0,
    mem_arbiter2_if.slave  m1,
    mem_arbiter2_if.master s,
    output logic           timeout_err
);

    localparam logic [1:0] StIdle  = IDLE;
    localparam logic [1:0] StBusy0 = BUSY0;
    localparam logic [1:0] StBusy1 = BUSY1;

    localparam int unsigned CntRaw = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned CntW   = (CntRaw < 8) ? 8 : ((CntRaw > 32) ? 32 : CntRaw);

    logic [1:0]      state_q, state_d;
    logic            last_gnt_q, last_gnt_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    mem_req_t m0_req, m1_req, cur_req, sel_req;
    mem_rsp_t s_rsp, rsp, m0_rsp, m1_rsp;
    logic [1:0] gnt;
    logic       own;
    logic       wd_hit;

    assign m0_req = '{valid: m0.mem_valid, instr: m0.mem_instr, addr: m0.mem_addr,
                      wdata: m0.mem_wdata, wstrb: m0.mem_wstrb};
    assign m1_req = '{valid: m1.mem_valid, instr: m1.mem_instr, addr: m1.mem_addr,
                      wdata: m1.mem_wdata, wstrb: m1.mem_wstrb};
    assign s_rsp  = '{ready: s.mem_ready, rdata: s.mem_rdata};

    rr_pick2 u_pick (
        .req_i      ({m1_req.valid, m0_req.valid}),
        .last_gnt_i (last_gnt_q),
        .gnt_o      (gnt)
    );

    assign own     = (state_q == StBusy1);
    assign cur_req = own ? m1_req : m0_req;
    assign wd_hit  = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES));

    always_comb begin
        state_d     = state_q;
        last_gnt_d  = last_gnt_q;
        cnt_d       = '0;
        sel_req     = '0;
        rsp         = '0;
        m0_rsp      = '0;
        m1_rsp      = '0;
        timeout_err = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (gnt[0]) begin
                    state_d = StBusy0;
                end else if (gnt[1]) begin
                    state_d = StBusy1;
                end
            end
            StBusy0, StBusy1: begin
                sel_req = cur_req;
                rsp     = s_rsp;
                // Slave ready wins over both abort and the watchdog.
                if (s_rsp.ready) begin
                    state_d    = StIdle;
                    last_gnt_d = own;
                end else if (!cur_req.valid) begin
                    // Master abort: no ready, round-robin pointer untouched.
                    state_d = StIdle;
                end else if (wd_hit) begin
                    sel_req.valid = 1'b0;
                    rsp           = '{ready: 1'b1, rdata: ERR_RDATA};
                    timeout_err   = 1'b1;
                    state_d       = StIdle;
                    last_gnt_d    = own;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
                if (own) begin
                    m1_rsp = rsp;
                end else begin
                    m0_rsp = rsp;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            last_gnt_q <= 1'b1;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            cnt_q      <= cnt_d;
        end
    end

    assign s.mem_valid = sel_req.valid;
    assign s.mem_instr = sel_req.instr;
    assign s.mem_addr  = sel_req.addr;
    assign s.mem_wdata = sel_req.wdata;
    assign s.mem_wstrb = sel_req.wstrb;

    assign m0.mem_ready = m0_rsp.ready;
    assign m0.mem_rdata = m0_rsp.rdata;
    assign m1.mem_ready = m1_rsp.ready;
    assign m1.mem_rdata = m1_rsp.rdata;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2 with an 8-cycle watchdog and a tiny slave model.
module tb_mem_arbiter2;

    logic clk = 1'b0;
    logic resetn;
    logic slv_rdy;
    logic timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    mem_arbiter2_if m0_bus ();
    mem_arbiter2_if m1_bus ();
    mem_arbiter2_if s_bus ();

    mem_arbiter2 #(
        .TIMEOUT_CYCLES (8),
        .ERR_RDATA      (32'hDEAD_DEAD)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .m0          (m0_bus),
        .m1          (m1_bus),
        .s           (s_bus),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Slave model: 16 words; unwritten words read as 0x1000_0000 | word index.
    logic [31:0] mem [16];
    logic [15:0] wr_vld = '0;
    logic [3:0]  idx;
    assign idx = s_bus.mem_addr[5:2];
    assign s_bus.mem_ready = slv_rdy;
    assign s_bus.mem_rdata = wr_vld[idx] ? mem[idx] : {28'h1000000, idx};

    always @(posedge clk) begin
        if (s_bus.mem_valid && slv_rdy && (s_bus.mem_wstrb != 4'h0)) begin
            mem[idx]    <= s_bus.mem_wdata;
            wr_vld[idx] <= 1'b1;
        end
    end

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m0(input logic v, input logic ins, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st);
        m0_bus.mem_valid = v;
        m0_bus.mem_instr = ins;
        m0_bus.mem_addr  = a;
        m0_bus.mem_wdata = d;
        m0_bus.mem_wstrb = st;
    endtask

    task automatic set_m1(input logic v, input logic ins, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] st);
        m1_bus.mem_valid = v;
        m1_bus.mem_instr = ins;
        m1_bus.mem_addr  = a;
        m1_bus.mem_wdata = d;
        m1_bus.mem_wstrb = st;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        logic m0_turn;
        resetn  = 1'b0;
        slv_rdy = 1'b0;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Reset state.
        #12;
        chk1("rst_s_valid", s_bus.mem_valid, 1'b0);
        chk32("rst_s_addr", s_bus.mem_addr, 32'h0);
        chk1("rst_m0_ready", m0_bus.mem_ready, 1'b0);
        chk1("rst_m1_ready", m1_bus.mem_ready, 1'b0);
        chk1("rst_timeout", timeout_err, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // Single master write then read-back, zero-wait slave.
        slv_rdy = 1'b1;
        set_m0(1'b1, 1'b0, 32'h0001_0000, 32'hDEADBEEF, 4'hF);
        #1;
        chk1("wr_idle_s_valid", s_bus.mem_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        chk1("wr_s_valid", s_bus.mem_valid, 1'b1);
        chk32("wr_s_addr", s_bus.mem_addr, 32'h0001_0000);
        chk32("wr_s_wdata", s_bus.mem_wdata, 32'hDEADBEEF);
        chk32("wr_s_wstrb", {28'h0, s_bus.mem_wstrb}, 32'hF);
        chk1("wr_m0_ready", m0_bus.mem_ready, 1'b1);
        chk1("wr_m1_ready", m1_bus.mem_ready, 1'b0);
        @(posedge clk); #1;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk1("wr_ready_single_pulse", m0_bus.mem_ready, 1'b0);
        set_m0(1'b1, 1'b0, 32'h0001_0000, 32'h0, 4'h0);
        @(posedge clk); @(negedge clk);
        chk1("rd_m0_ready", m0_bus.mem_ready, 1'b1);
        chk32("rd_m0_rdata", m0_bus.mem_rdata, 32'hDEADBEEF);
        chk32("rd_s_wstrb", {28'h0, s_bus.mem_wstrb}, 32'h0);
        @(posedge clk); #1;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Contention after reset: m0 first, IDLE gap, then alternation.
        @(negedge clk);
        resetn = 1'b0;
        #1;
        resetn = 1'b1;
        set_m0(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        set_m1(1'b1, 1'b1, 32'h8, 32'h0, 4'h0);
        for (int k = 0; k < 4; k++) begin
            m0_turn = ((k % 2) == 0);
            @(posedge clk); @(negedge clk);
            chk1("rr_s_valid", s_bus.mem_valid, 1'b1);
            chk32("rr_s_addr", s_bus.mem_addr, m0_turn ? 32'h4 : 32'h8);
            chk1("rr_s_instr", s_bus.mem_instr, ~m0_turn);
            chk1("rr_m0_ready", m0_bus.mem_ready, m0_turn);
            chk1("rr_m1_ready", m1_bus.mem_ready, ~m0_turn);
            chk32("rr_m0_rdata", m0_bus.mem_rdata, m0_turn ? 32'h1000_0001 : 32'h0);
            chk32("rr_m1_rdata", m1_bus.mem_rdata, m0_turn ? 32'h0 : 32'h1000_0002);
            @(posedge clk); @(negedge clk);
            chk1("rr_idle_gap", s_bus.mem_valid, 1'b0);
        end

        // Wait states: m0 granted, slave ready after 3 wait cycles, m1 waits.
        slv_rdy = 1'b0;
        set_m0(1'b1, 1'b0, 32'hC, 32'hCAFEF00D, 4'hF);
        set_m1(1'b1, 1'b0, 32'h8, 32'h0, 4'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); @(negedge clk);
            chk32("ws_s_addr", s_bus.mem_addr, 32'hC);
            chk32("ws_s_wdata", s_bus.mem_wdata, 32'hCAFEF00D);
            chk1("ws_m0_ready", m0_bus.mem_ready, 1'b0);
            chk1("ws_m1_ready", m1_bus.mem_ready, 1'b0);
        end
        @(posedge clk); #1;
        slv_rdy = 1'b1;
        @(negedge clk);
        chk1("ws_done_m0_ready", m0_bus.mem_ready, 1'b1);
        chk1("ws_done_m1_ready", m1_bus.mem_ready, 1'b0);
        chk32("ws_done_m1_rdata", m1_bus.mem_rdata, 32'h0);
        @(posedge clk); #1;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk1("ws_idle_gap", s_bus.mem_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        chk1("ws_m1_ready", m1_bus.mem_ready, 1'b1);
        chk32("ws_m1_rdata", m1_bus.mem_rdata, 32'h1000_0002);
        chk1("ws_m0_no_ready", m0_bus.mem_ready, 1'b0);
        @(posedge clk); #1;
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slv_rdy = 1'b0;

        // Timeout: slave never ready, error on the 9th BUSY cycle.
        @(negedge clk);
        set_m1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            chk1("to_wait_s_valid", s_bus.mem_valid, 1'b1);
            chk1("to_wait_m1_ready", m1_bus.mem_ready, 1'b0);
            chk1("to_wait_err", timeout_err, 1'b0);
        end
        @(posedge clk); @(negedge clk);
        chk1("to_m1_ready", m1_bus.mem_ready, 1'b1);
        chk32("to_m1_rdata", m1_bus.mem_rdata, 32'hDEAD_DEAD);
        chk1("to_err", timeout_err, 1'b1);
        chk1("to_s_valid_forced", s_bus.mem_valid, 1'b0);
        chk1("to_m0_ready", m0_bus.mem_ready, 1'b0);
        @(posedge clk); #1;
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk1("to_err_pulse", timeout_err, 1'b0);
        slv_rdy = 1'b1;
        set_m0(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        @(posedge clk); @(negedge clk);
        chk1("after_to_m0_ready", m0_bus.mem_ready, 1'b1);
        chk32("after_to_m0_rdata", m0_bus.mem_rdata, 32'h1000_0001);
        chk1("after_to_err", timeout_err, 1'b0);
        @(posedge clk); #1;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slv_rdy = 1'b0;

        // Slave ready exactly at the terminal count wins over the watchdog.
        @(negedge clk);
        set_m0(1'b1, 1'b0, 32'hC, 32'h0, 4'h0);
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); @(negedge clk);
            chk1("tc_wait_m0_ready", m0_bus.mem_ready, 1'b0);
        end
        @(posedge clk); #1;
        slv_rdy = 1'b1;
        @(negedge clk);
        chk1("tc_m0_ready", m0_bus.mem_ready, 1'b1);
        chk32("tc_m0_rdata", m0_bus.mem_rdata, 32'hCAFEF00D);
        chk1("tc_err", timeout_err, 1'b0);
        chk1("tc_s_valid", s_bus.mem_valid, 1'b1);
        @(posedge clk); #1;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slv_rdy = 1'b0;

        // Reset during BUSY1, then dual request grants m0 first.
        @(negedge clk);
        set_m1(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        @(posedge clk); @(negedge clk);
        chk1("mr_busy_s_valid", s_bus.mem_valid, 1'b1);
        chk32("mr_busy_m1_rdata", m1_bus.mem_rdata, 32'h1000_0004);
        #1;
        resetn = 1'b0;
        #1;
        chk1("mr_rst_s_valid", s_bus.mem_valid, 1'b0);
        chk32("mr_rst_s_addr", s_bus.mem_addr, 32'h0);
        chk32("mr_rst_m1_rdata", m1_bus.mem_rdata, 32'h0);
        chk1("mr_rst_m1_ready", m1_bus.mem_ready, 1'b0);
        set_m0(1'b1, 1'b0, 32'h4, 32'h0, 4'h0);
        slv_rdy = 1'b1;
        resetn  = 1'b1;
        @(posedge clk); @(negedge clk);
        chk1("mr_m0_first", m0_bus.mem_ready, 1'b1);
        chk32("mr_s_addr", s_bus.mem_addr, 32'h4);
        chk1("mr_m1_wait", m1_bus.mem_ready, 1'b0);
        @(posedge clk); #1;
        set_m0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        @(negedge clk);
        chk1("mr_idle_gap", s_bus.mem_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        chk1("mr_m1_ready", m1_bus.mem_ready, 1'b1);
        chk32("mr_m1_rdata", m1_bus.mem_rdata, 32'h1000_0004);
        @(posedge clk); #1;
        set_m1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        slv_rdy = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-master arbiter for the PicoRV32-style native memory bus, placed directly upstream of `simple_mem`. It accepts requests from two bus masters, m0 (CPU) and m1 (loader/debug), and grants one at a time using round-robin priority. The granted master's transaction is forwarded to the single slave port. A cycle-count watchdog completes any slave transaction that stalls.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 255: cycles in BUSY without `s_mem_ready` before a forced completion; 0 disables the watchdog.
- `ERR_RDATA`, default 32'hDEAD_DEAD: read data returned to the master on a timeout.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `m0_mem_valid`, `m1_mem_valid` in 1: master request.
- `m0_mem_instr`, `m1_mem_instr` in 1: instruction-fetch flag.
- `m0_mem_addr`, `m1_mem_addr` in 32: byte address.
- `m0_mem_wdata`, `m1_mem_wdata` in 32: write data.
- `m0_mem_wstrb`, `m1_mem_wstrb` in 4: byte enables; 0 means read.
- `m0_mem_ready`, `m1_mem_ready` out 1: transfer complete, one-cycle pulse.
- `m0_mem_rdata`, `m1_mem_rdata` out 32: read data, valid while the matching ready is high.
- `s_mem_valid` out 1, `s_mem_instr` out 1, `s_mem_addr` out 32, `s_mem_wdata` out 32, `s_mem_wstrb` out 4: slave request.
- `s_mem_ready` in 1, `s_mem_rdata` in 32: slave response.
- `timeout_err` out 1: one-cycle pulse when the watchdog fires.

## Operation
- States are IDLE, BUSY0 and BUSY1. A registered `last_gnt` bit records the master most recently served.
- **IDLE:**
  - All `s_*` outputs are 0. All `m*_mem_ready` are 0.
  - If only one master requests, go to BUSY of that master.
  - If both request, go to BUSY of the master that is not `last_gnt`.
- **BUSYn:**
  - `s_mem_valid/instr/addr/wdata/wstrb` are driven combinationally from master n.
  - `mn_mem_ready` equals `s_mem_ready`. `mn_mem_rdata` equals `s_mem_rdata`.
  - The other master's ready and rdata are 0.
- **Completion:**
  - When `s_mem_ready` is high in BUSYn, set `last_gnt <= n`, clear the watchdog and return to IDLE.
  - Back-to-back grants always include one IDLE cycle between them.
- **Watchdog:**
  - An 8-to-32-bit counter, sized $clog2(TIMEOUT_CYCLES+1), increments every BUSY cycle without ready.
  - When it reaches `TIMEOUT_CYCLES`, the following all happen in that cycle:
    - `s_mem_valid` is forced to 0.
    - `mn_mem_ready` is 1 with `mn_mem_rdata = ERR_RDATA`.
    - `timeout_err` is 1.
  - The next state is IDLE and `last_gnt <= n`.
- **Master abort:** if master n drops valid while in BUSYn without ready:
  - `s_mem_valid` follows it low in the same cycle.
  - The next state is IDLE.
  - No ready is issued and `last_gnt` is unchanged.
- **Simultaneous events:** if `s_mem_ready` and the watchdog terminal count occur in the same cycle, `s_mem_ready` wins; no error is raised and the slave's rdata is returned.

## Timing
- Reset, asynchronous:
  - State is IDLE and `last_gnt = 1`, so m0 wins the first contention.
  - Watchdog counter is 0.
  - Every output is 0.
  - Asserting reset mid-transfer drops all outputs to 0 immediately.
- Grant latency: a request first seen at edge N is driven on `s_mem_*` from edge N+1.
- With a zero-wait slave (`s_mem_ready` tied 1), the master sees ready in cycle N+1. Throughput is then one transfer per 2 cycles per master.
- A master must hold valid, address, data and strobes stable until its ready. The arbiter does not register these fields.

## Structure
- Package `mem_bus_pkg` holds:
  - `arb_state_t`, an enum of IDLE, BUSY0 and BUSY1.
  - `mem_req_t`, a struct of valid, instr, addr, wdata and wstrb.
  - `mem_rsp_t`, a struct of ready and rdata.
  - `ERR_RDATA_DEFAULT`.
- One sub-module, `rr_pick2`. It takes two request bits and `last_gnt` and returns a one-hot grant. It is combinational and reusable by future multi-port bridges.
- Top level: state register, watchdog counter and request/response muxes.

## Test plan
- **Single master:** m0 writes 32'hDEADBEEF to 32'h0001_0000 with wstrb 4'b1111, slave ready tied 1.
  - `s_mem_*` match from the next edge and `m0_mem_ready` pulses once.
  - m0 then reads back 32'hDEADBEEF.
- **Contention after reset:** both masters request on the same edge.
  - m0 is granted first, then IDLE, then m1.
  - Repeat the dual request: m0 and m1 alternate across 4 transfers.
- **Wait states:** slave delays ready by 3 cycles.
  - The request stays stable and m1 sees no ready throughout.
  - Ready is passed through only to the granted master.
- **Timeout:** `TIMEOUT_CYCLES` = 8 and slave never ready.
  - In the 9th BUSY cycle the master gets ready with 32'hDEAD_DEAD and `timeout_err` pulses.
  - The next request is still served normally.
- **Ready at terminal count:** slave ready arrives exactly on the terminal count.
  - Slave data is returned and `timeout_err` stays 0.
- **Reset mid-transfer:** `resetn` low during BUSY1.
  - All outputs go to 0 asynchronously.
  - After release, a dual request grants m0 first.
